// File: rtl/seq_arith_pkg.sv
// Shared definitions for the sequential-arithmetic family.
//   op_t        : operation encoding carried on the 2-bit op input
//   operand_t   : effective B bit and initial carry for one full-adder step
//   map_operand : turns (op, in_b) into (b', cin) so that every operation
//                 reduces to a single ripple add of A and b'
package seq_arith_pkg;

    typedef enum logic [1:0] {
        OP_INCR = 2'd0,
        OP_DECR = 2'd1,
        OP_ADD  = 2'd2,
        OP_SUB  = 2'd3
    } op_t;

    typedef struct packed {
        logic b_eff;
        logic cin;
    } operand_t;

    // INCR adds 0 with carry-in 1, DECR adds all-ones (two's complement -1),
    // SUB adds ~B with carry-in 1.
    function automatic operand_t map_operand(input op_t op, input logic b);
        operand_t r;
        r = '0;
        case (op)
            OP_INCR: begin r.b_eff = 1'b0; r.cin = 1'b1; end
            OP_DECR: begin r.b_eff = 1'b1; r.cin = 1'b0; end
            OP_ADD:  begin r.b_eff = b;    r.cin = 1'b0; end
            OP_SUB:  begin r.b_eff = ~b;   r.cin = 1'b1; end
            default: begin r.b_eff = 1'b0; r.cin = 1'b0; end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_arith_full_adder.sv
// Combinational 1-bit full adder.
//   a, b, cin : addend bits and carry in
//   sum       : a ^ b ^ cin
//   cout      : majority(a, b, cin)
module seq_arith_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_arith_serial_addsub.sv
// Bit-serial increment / decrement / add / subtract, LSB first.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : in_a / in_b / op carry a valid bit this cycle
//   in_a, in_b : operand bits (in_b ignored for INCR/DECR)
//   op         : operation, sampled on the first bit of a word only
//   out_valid  : registered result bit valid (one cycle after input)
//   out        : result bit
//   out_last   : marks the MSB result bit
//   out_cout   : carry out of the MSB, on the last bit only
//   out_ovf    : signed overflow, on the last bit only
// All outputs are forced to 0 whenever they are not qualified.
module seq_arith_serial_addsub
    import seq_arith_pkg::*;
#(
    parameter int NBITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_a,
    input  logic       in_b,
    input  logic [1:0] op,
    output logic       out_valid,
    output logic       out,
    output logic       out_last,
    output logic       out_cout,
    output logic       out_ovf
);

    localparam int             CW       = $clog2(NBITS);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NBITS - 1);

    logic [CW-1:0] count;
    logic          carry;
    op_t           op_q;

    logic          first_bit;
    logic          last_bit;
    op_t           op_eff;
    operand_t      opnd;
    logic          c_in;
    logic          sum;
    logic          c_out;

    // ------------------------------------------------------------------
    // First/last decode and operand selection. On the first bit the live
    // op input is used directly so the word needs no set-up cycle.
    // ------------------------------------------------------------------
    always_comb begin
        first_bit = in_valid && (count == '0);
        last_bit  = (count == LAST_IDX);
        op_eff    = first_bit ? op_t'(op) : op_q;
        opnd      = map_operand(op_eff, in_b);
        // The carry register holds stale data from the previous word at a
        // word start; the operation's seed carry replaces it.
        c_in      = first_bit ? opnd.cin : carry;
    end

    seq_arith_full_adder u_fa (
        .a    (in_a),
        .b    (opnd.b_eff),
        .cin  (c_in),
        .sum  (sum),
        .cout (c_out)
    );

    // ------------------------------------------------------------------
    // Word state: bit counter, running carry, latched operation.
    // in_valid low freezes everything so gaps are transparent.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            carry <= 1'b0;
            op_q  <= OP_INCR;
        end else if (in_valid) begin
            count <= last_bit ? '0 : count + 1'b1;
            carry <= c_out;
            if (first_bit)
                op_q <= op_eff;
        end
    end

    // ------------------------------------------------------------------
    // Output register. On the MSB, c_in is the carry into the MSB, so
    // c_in ^ c_out is exactly the signed overflow condition.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= 1'b0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out       <= in_valid & sum;
            out_last  <= in_valid & last_bit;
            out_cout  <= in_valid & last_bit & c_out;
            out_ovf   <= in_valid & last_bit & (c_in ^ c_out);
        end
    end

endmodule

// File: tb/tb_seq_arith_serial_addsub.sv
// Directed + randomised bench for seq_arith_serial_addsub, run against a
// 4-bit and an 8-bit instance sharing clock and reset.
module tb_seq_arith_serial_addsub;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] iv = '0, ia = '0, ib = '0;
    logic [1:0] op0 = '0, op1 = '0;
    logic [1:0] ov, o_bit, ol, oc, oo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] sb[$];

    always #5 clk = ~clk;

    seq_arith_serial_addsub #(.NBITS(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_a(ia[0]), .in_b(ib[0]),
        .op(op0), .out_valid(ov[0]), .out(o_bit[0]), .out_last(ol[0]),
        .out_cout(oc[0]), .out_ovf(oo[0])
    );

    seq_arith_serial_addsub #(.NBITS(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_a(ia[1]), .in_b(ib[1]),
        .op(op1), .out_valid(ov[1]), .out(o_bit[1]), .out_last(ol[1]),
        .out_cout(oc[1]), .out_ovf(oo[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic v, input logic a, input logic b,
                         input logic [1:0] o);
        if (s == 0) begin iv[0] = v; ia[0] = a; ib[0] = b; op0 = o; end
        else        begin iv[1] = v; ia[1] = a; ib[1] = b; op1 = o; end
    endtask

    // {out_valid, out, out_last, out_cout, out_ovf}
    function automatic logic [4:0] sample(input int s);
        return {ov[s], o_bit[s], ol[s], oc[s], oo[s]};
    endfunction

    // Streams one word into instance s following the in_valid pattern pat
    // (LSB first, plen cycles). Per-cycle expectations come from a word-level
    // two's-complement model and pass through the scoreboard queue.
    task automatic send_word(input string tag, input int s, input logic [1:0] o,
                             input logic [63:0] a_w, input logic [63:0] b_w,
                             input logic [31:0] pat, input int plen, input bit tog,
                             output logic [63:0] res, output logic co, output logic ovf);
        int          n, k, ko;
        logic [64:0] full;
        logic [63:0] mask, bw, rm;
        logic        ci, com, ovm;
        logic [4:0]  e, got;
        logic [1:0]  o_drv;
        n    = (s == 0) ? 4 : 8;
        mask = (64'd1 << n) - 64'd1;
        case (o)
            2'd0:    begin bw = '0;    ci = 1'b1; end
            2'd1:    begin bw = '1;    ci = 1'b0; end
            2'd2:    begin bw = b_w;   ci = 1'b0; end
            default: begin bw = ~b_w;  ci = 1'b1; end
        endcase
        full = {1'b0, a_w & mask} + {1'b0, bw & mask} + {64'd0, ci};
        rm   = full[63:0] & mask;
        com  = full[n];
        ovm  = (a_w[n-1] == bw[n-1]) && (rm[n-1] != a_w[n-1]);
        res = '0; co = 1'b0; ovf = 1'b0;
        k = 0; ko = 0;
        for (int c = 0; c < plen; c++) begin
            if (pat[c] && k < n) begin
                o_drv = (k == 0 || !tog) ? o : ~o;
                drive(s, 1'b1, a_w[k], b_w[k], o_drv);
                e = {1'b1, rm[k], (k == n-1), (k == n-1) & com, (k == n-1) & ovm};
                k++;
            end else begin
                drive(s, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
                e = 5'b0;
            end
            sb.push_back(e);
            @(posedge clk); #1;
            got = sample(s);
            chk(tag, {59'd0, got}, {59'd0, sb.pop_front()});
            if (got[4] && ko < 64) begin
                res[ko] = got[3];
                if (got[2]) begin co = got[1]; ovf = got[0]; end
                ko++;
            end
        end
        drive(s, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        logic [63:0] r;
        logic        co, ovf;
        logic [31:0] pat;
        int          plen, cnt, n, s;

        // Reset with in_valid high on both instances: reset wins.
        drive(0, 1'b1, 1'b1, 1'b1, 2'd2);
        drive(1, 1'b1, 1'b1, 1'b1, 2'd2);
        repeat (2) begin
            @(posedge clk); #1;
            chk("reset4", {59'd0, sample(0)}, 64'd0);
            chk("reset8", {59'd0, sample(1)}, 64'd0);
        end
        drive(0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle4", {59'd0, sample(0)}, 64'd0);

        // INCR 0111
        send_word("incr0111", 0, 2'd0, 64'h7, 64'h0, 32'hF, 4, 1'b0, r, co, ovf);
        chk("incr0111_res", r, 64'h8);
        chk("incr0111_cout", {63'd0, co}, 64'd0);
        chk("incr0111_ovf", {63'd0, ovf}, 64'd1);

        // INCR 1111 then DECR 0000 back-to-back
        send_word("incr1111", 0, 2'd0, 64'hF, 64'h0, 32'hF, 4, 1'b0, r, co, ovf);
        chk("incr1111_res", r, 64'h0);
        chk("incr1111_cout", {63'd0, co}, 64'd1);
        chk("incr1111_ovf", {63'd0, ovf}, 64'd0);
        send_word("decr0000", 0, 2'd1, 64'h0, 64'h0, 32'hF, 4, 1'b0, r, co, ovf);
        chk("decr0000_res", r, 64'hF);
        chk("decr0000_cout", {63'd0, co}, 64'd0);
        chk("decr0000_ovf", {63'd0, ovf}, 64'd0);

        // SUB then ADD with op toggled on non-first bits
        send_word("sub", 0, 2'd3, 64'h5, 64'h3, 32'hF, 4, 1'b1, r, co, ovf);
        chk("sub_res", r, 64'h2);
        chk("sub_cout", {63'd0, co}, 64'd1);
        chk("sub_ovf", {63'd0, ovf}, 64'd0);
        send_word("add", 0, 2'd2, 64'h7, 64'h1, 32'hF, 4, 1'b1, r, co, ovf);
        chk("add_res", r, 64'h8);
        chk("add_cout", {63'd0, co}, 64'd0);
        chk("add_ovf", {63'd0, ovf}, 64'd1);

        // Gaps: in_valid 1,0,0,1,1,0,1
        send_word("gaps", 0, 2'd2, 64'hB, 64'h6, 32'b1011001, 7, 1'b0, r, co, ovf);
        chk("gaps_res", r, 64'h1);
        chk("gaps_cout", {63'd0, co}, 64'd1);
        chk("gaps_ovf", {63'd0, ovf}, 64'd0);

        // Reset mid-word after 2 bits of INCR (in_valid held high in reset)
        send_word("partial", 0, 2'd0, 64'h5, 64'h0, 32'h3, 2, 1'b0, r, co, ovf);
        reset = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 2'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        chk("after_reset", {59'd0, sample(0)}, 64'd0);
        send_word("incr0011", 0, 2'd0, 64'h3, 64'h0, 32'hF, 4, 1'b0, r, co, ovf);
        chk("incr0011_res", r, 64'h4);
        chk("incr0011_cout", {63'd0, co}, 64'd0);

        // NBITS=8: INCR 0xFF
        send_word("incrFF", 1, 2'd0, 64'hFF, 64'h0, 32'hFF, 8, 1'b0, r, co, ovf);
        chk("incrFF_res", r, 64'h0);
        chk("incrFF_cout", {63'd0, co}, 64'd1);

        // Randomised ops, operands and gaps on both widths
        for (int it = 0; it < 60; it++) begin
            s = $urandom_range(0, 1);
            n = (s == 0) ? 4 : 8;
            pat = '0; plen = 0; cnt = 0;
            while (cnt < n) begin
                if (plen >= 20 || $urandom_range(0, 2) != 0) begin
                    pat[plen] = 1'b1;
                    cnt++;
                end
                plen++;
            end
            send_word("random", s, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                      pat, plen, 1'($urandom), r, co, ovf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_arith_serial_addsub.md
# seq_arith_serial_addsub

Parametrised bit-serial arithmetic unit for the sequential-arithmetic family. It processes NBITS-wide words LSB first, one bit per valid cycle, and supports increment, decrement, add and subtract. Words are framed by an input valid, and gaps between bits are tolerated. Each output bit is registered, and the final bit of each word carries the carry-out and signed-overflow flags.

## Interface
- NBITS, 4, word width in bits; legal range 2..64
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  current in_a/in_b/op bits are valid this cycle
- in_a  input  1  operand A bit, LSB first
- in_b  input  1  operand B bit, LSB first; ignored for INCR/DECR
- op  input  2  operation; sampled only on the first bit of a word
- out_valid  output  1  out/out_last/flags valid this cycle
- out  output  1  result bit, LSB first
- out_last  output  1  high with the MSB result bit
- out_cout  output  1  carry out of MSB; valid only when out_last=1
- out_ovf  output  1  signed overflow; valid only when out_last=1

## Operation
- Op encoding: 0 INCR (A+1), 1 DECR (A−1), 2 ADD (A+B), 3 SUB (A−B).
- Operand mapping per bit is b' and initial carry cin:
  - INCR: b'=0, cin=1
  - DECR: b'=1, cin=0
  - ADD: b'=in_b, cin=0
  - SUB: b'=~in_b, cin=1
- State:
  - bit counter `count`, width $clog2(NBITS)
  - carry register
  - latched op register
- Word start is any cycle with in_valid=1 and count=0.
  - op is captured into the op register.
  - The full adder uses cin instead of the carry register.
- Every valid bit:
  - sum = a ^ b' ^ c; carry_next = majority(a, b', c).
  - count increments.
  - When count=NBITS−1, count wraps to 0 and the carry is don't-care, because the next word re-seeds it.
- in_valid=0 pauses the word: count, carry and op hold, and mid-word gaps of any length are legal.
- The op input is ignored on every bit except the first of a word.
- Flags on the last bit:
  - out_cout = carry_next (for SUB, 1 means no borrow).
  - out_ovf = carry into the MSB XOR carry out of the MSB.
- Back-to-back words with no idle cycle are fully supported.

## Timing
- Latency is 1 cycle: a bit accepted at edge k appears on the outputs after edge k, so out_valid follows in_valid delayed by one cycle.
- Reset values:
  - out_valid=0, out=0, out_last=0, out_cout=0, out_ovf=0
  - count=0, carry=0, op register=INCR
- When out_valid=0, out, out_last, out_cout and out_ovf are all 0.
- out_cout and out_ovf are 0 on any output cycle where out_last=0.
- Reset mid-word: the partial word is abandoned and count returns to 0. out_valid=0 on the cycle after reset, even if in_valid=1 during reset. The first valid bit after reset deasserts is a word start.
- Reset asserted together with in_valid: reset wins and the bit is dropped.
- There is no backpressure; the consumer must accept every out_valid cycle.

## Structure
- Shared package `seq_arith_pkg` holds:
  - the `op_t` enum (OP_INCR, OP_DECR, OP_ADD, OP_SUB)
  - the helper that maps (op, in_b) to (b', cin)
- One sub-module is natural: `seq_arith_full_adder`, a combinational 1-bit full adder producing sum and cout. The top level computes the carry into the MSB from its inputs for the overflow flag.
- Top level contains:
  - counter and carry/op registers
  - output register stage
  - first/last-bit decode

## Test plan
- INCR 0111 (NBITS=4): in_a bits 1,1,1,0 with in_valid=1 for 4 cycles.
  - Required: out 0,0,0,1 one cycle later, out_last on the 4th bit, cout=0, ovf=1.
- INCR 1111 followed back-to-back by DECR 0000.
  - Word 1 required: 0000, cout=1, ovf=0.
  - Word 2 required: 1111, cout=0, ovf=0.
  - Also checks that op is re-latched at the word boundary.
- SUB then ADD.
  - SUB 0101−0011 required: 0010, cout=1, ovf=0.
  - ADD 0111+0001 required: 1000, cout=0, ovf=1.
  - During these words, op is toggled on non-first bits; the toggles must have no effect.
- Gaps: ADD 1011+0110 with in_valid pattern 1,0,0,1,1,0,1.
  - Required: out_valid is 0 during gaps and out bits are 1,0,0,0.
  - Required on the last bit: out_last=1, cout=1, ovf=0.
- Reset mid-word: assert reset after 2 bits of an INCR, then send a full INCR 0011.
  - Required: out_valid=0 on the cycle after reset, then result 0100 with cout=0.
- NBITS=8: INCR 0xFF.
  - Required: out_last only on the 8th output bit, result 0x00, cout=1.
- Randomised ops and gaps checked against a golden model (not counted as a directed scenario).
